// File: rtl/core_pkg.sv
// Shared core definitions for the fetch-side instruction memory.
//   INST_W_C     : native instruction word width
//   NOP_INST     : word presented on o_inst when no fetch is served
//   BYTE_W       : width of one load-port byte
//   imem_state_e : instruction-memory loader FSM states
package core_pkg;

  localparam int unsigned INST_W_C = 32;
  localparam int unsigned BYTE_W   = 8;

  localparam logic [INST_W_C-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [0:0] {
    IMEM_IDLE,
    IMEM_LOAD
  } imem_state_e;

endpackage

// File: rtl/inst_rom_resp_if.sv
// Fetch and byte-serial load bus between the PC stage / loader and inst_rom_resp.
//   i_ce, i_addr                : fetch request from the PC stage
//   o_inst, o_inst_vld          : fetched word, one cycle after the request
//   o_busy                      : load in progress, fetches not served
//   i_ld_start                  : pulse, begin loading at word 0
//   i_ld_vld, i_ld_byte, o_ld_rdy : byte-serial load handshake (MSB-first)
//   o_ld_done                   : pulse after the last word is written
// master = driver side (PC stage + loader), slave = the memory responder.
interface inst_rom_resp_if #(
  parameter int unsigned NPC    = 6,
  parameter int unsigned INST_W = 32
);

  logic              i_ce;
  logic [NPC-1:0]    i_addr;
  logic [INST_W-1:0] o_inst;
  logic              o_inst_vld;
  logic              o_busy;
  logic              i_ld_start;
  logic              i_ld_vld;
  logic [7:0]        i_ld_byte;
  logic              o_ld_rdy;
  logic              o_ld_done;

  modport master (
    output i_ce, i_addr, i_ld_start, i_ld_vld, i_ld_byte,
    input  o_inst, o_inst_vld, o_busy, o_ld_rdy, o_ld_done
  );

  modport slave (
    input  i_ce, i_addr, i_ld_start, i_ld_vld, i_ld_byte,
    output o_inst, o_inst_vld, o_busy, o_ld_rdy, o_ld_done
  );

endinterface

// File: rtl/inst_rom_resp_ram.sv
// imem_ram: 2**AW x DW instruction array, one synchronous write port and one
// synchronous read port. The read register returns NOP_INST whenever no read
// is requested, so it can drive the fetched-instruction output directly.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we, waddr, wdata    : write port
//   re, raddr, rdata    : read port, 1-cycle latency
module imem_ram
  import core_pkg::*;
#(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Array contents survive reset; only the loader changes them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register doubles as the output gate: unserved cycles read as NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= DW'(NOP_INST);
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= DW'(NOP_INST);
    end
  end

endmodule

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: instruction-memory responder between the PC stage and IF/ID.
// Serves one fetch per cycle with 1-cycle latency while idle; after
// i_ld_start it accepts a full-depth byte-serial (big-endian) load, during
// which fetches return NOP with o_inst_vld low.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : fetch request/response and load handshake, see inst_rom_resp_if
module inst_rom_resp
  import core_pkg::*;
#(
  parameter int unsigned NPC    = 6,
  parameter int unsigned INST_W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  inst_rom_resp_if.slave bus
);

  localparam int unsigned BYTES = INST_W / BYTE_W;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [NPC-1:0]   LAST_WORD = {NPC{1'b1}};

  imem_state_e       state_q, state_d;
  logic [NPC-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INST_W-1:0] asm_q, asm_d;
  logic              load_q;
  logic              vld_q;
  logic              done_q, done_d;

  logic              we_c;
  logic              re_c;
  logic [INST_W-1:0] wdata_c;
  logic [INST_W-1:0] inst_c;

  // Next-state, byte assembly and memory port control.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    done_d  = 1'b0;
    we_c    = 1'b0;
    re_c    = 1'b0;
    wdata_c = (asm_q << BYTE_W) | INST_W'(bus.i_ld_byte);

    unique case (state_q)
      IMEM_IDLE: begin
        // A fetch in the start cycle is still served; loading begins next cycle.
        re_c = bus.i_ce;
        if (bus.i_ld_start) begin
          state_d = IMEM_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      IMEM_LOAD: begin
        if (bus.i_ld_vld && load_q) begin
          asm_d = wdata_c;
          if (cnt_q == LAST_BYTE) begin
            we_c  = 1'b1;
            cnt_d = '0;
            ptr_d = ptr_q + NPC'(1);
            if (ptr_q == LAST_WORD) begin
              done_d  = 1'b1;
              state_d = IMEM_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IMEM_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any partially assembled word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IMEM_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      load_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      load_q  <= (state_d == IMEM_LOAD);
      vld_q   <= re_c;
      done_q  <= done_d;
    end
  end

  imem_ram #(
    .AW (NPC),
    .DW (INST_W)
  ) u_ram (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .we    (we_c),
    .waddr (ptr_q),
    .wdata (wdata_c),
    .re    (re_c),
    .raddr (bus.i_addr),
    .rdata (inst_c)
  );

  // Busy and ready are the same registered "loading" flag.
  assign bus.o_inst     = inst_c;
  assign bus.o_inst_vld = vld_q;
  assign bus.o_busy     = load_q;
  assign bus.o_ld_rdy   = load_q;
  assign bus.o_ld_done  = done_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: reset, full loads (steady and gapped),
// fetch sweeps from a vector table, simultaneous start/fetch and reset mid-load.
module tb_inst_rom_resp;

  localparam int unsigned NPC    = 6;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned NVEC   = DEPTH + 2;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  always #5 i_clk = ~i_clk;

  inst_rom_resp_if #(.NPC(NPC), .INST_W(INST_W)) bus ();

  inst_rom_resp #(.NPC(NPC), .INST_W(INST_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic              ce;
    logic [NPC-1:0]    addr;
    logic [INST_W-1:0] exp_inst;
    logic              exp_vld;
  } vec_t;

  vec_t vecs [NVEC];

  int checks      = 0;
  int failures    = 0;
  int cyc         = 0;
  int done_cnt    = 0;
  int done_cyc    = 0;
  int vld_in_load = 0;
  int busy_err    = 0;
  int first_cyc   = 0;
  bit load_watch  = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (bus.o_ld_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (load_watch && bus.o_inst_vld) vld_in_load = vld_in_load + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(int pat, int k);
    logic [7:0] k8;
    k8 = 8'(k);
    case (pat)
      1:       return {8'hA0 | {4'h0, k8[3:0]}, 16'h0000, k8};
      2:       return {k8, 8'h5A, ~k8, 8'hC3};
      3:       return 32'h1234_0000 | 32'(k);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All helpers start and end at a falling edge.
  task automatic start_load();
    bus.i_ld_start = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 2) == 0; g++) begin
        bus.i_ld_vld = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
      end
    end
    if (!bus.o_busy || !bus.o_ld_rdy) busy_err++;
    bus.i_ld_vld  = 1'b1;
    bus.i_ld_byte = b;
    @(posedge i_clk);
    @(negedge i_clk);
    bus.i_ld_vld  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int b = 0; b < 4; b++) begin
      logic [31:0] tmp;
      tmp = w >> (24 - 8 * b);
      send_byte(tmp[7:0], gaps);
    end
  endtask

  task automatic fill_table(input int pat);
    for (int k = 0; k < int'(DEPTH); k++) begin
      vecs[k].ce       = 1'b1;
      vecs[k].addr     = NPC'(k);
      vecs[k].exp_inst = word_of(pat, k);
      vecs[k].exp_vld  = 1'b1;
    end
    vecs[DEPTH].ce         = 1'b0;
    vecs[DEPTH].addr       = NPC'(5);
    vecs[DEPTH].exp_inst   = 32'h0;
    vecs[DEPTH].exp_vld    = 1'b0;
    vecs[DEPTH+1].ce       = 1'b1;
    vecs[DEPTH+1].addr     = NPC'(5);
    vecs[DEPTH+1].exp_inst = word_of(pat, 5);
    vecs[DEPTH+1].exp_vld  = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < int'(NVEC); i++) begin
      bus.i_ce   = vecs[i].ce;
      bus.i_addr = vecs[i].addr;
      @(posedge i_clk);
      #1;
      check($sformatf("%s_inst[%0d]", tag, i), bus.o_inst, vecs[i].exp_inst);
      check($sformatf("%s_vld[%0d]", tag, i), 32'(bus.o_inst_vld), 32'(vecs[i].exp_vld));
      @(negedge i_clk);
    end
  endtask

  task automatic fetch_check(input logic [NPC-1:0] a, input logic [31:0] exp, input string name);
    bus.i_ce   = 1'b1;
    bus.i_addr = a;
    @(posedge i_clk);
    #1;
    check(name, bus.o_inst, exp);
    check({name, "_vld"}, 32'(bus.o_inst_vld), 32'h1);
    @(negedge i_clk);
  endtask

  initial begin
    bus.i_ce       = 1'b1;
    bus.i_addr     = NPC'(3);
    bus.i_ld_start = 1'b0;
    bus.i_ld_vld   = 1'b0;
    bus.i_ld_byte  = 8'h00;

    // Reset held with fetch enable high: everything stays quiet.
    repeat (3) begin
      @(negedge i_clk);
      check("rst_inst", bus.o_inst, 32'h0);
      check("rst_flags", 32'({bus.o_inst_vld, bus.o_busy, bus.o_ld_rdy, bus.o_ld_done}), 32'h0);
    end
    i_rst_n = 1'b1;
    #1;
    check("post_rst_inst", bus.o_inst, 32'h0);
    check("post_rst_vld", 32'(bus.o_inst_vld), 32'h0);
    @(negedge i_clk);
    bus.i_ce = 1'b0;
    @(negedge i_clk);

    // Full load, valid held high.
    busy_err = 0;
    start_load();
    for (int k = 0; k < int'(DEPTH); k++) begin
      send_word(word_of(1, k), 1'b0);
      if (k == 0) first_cyc = cyc - 3;
    end
    #1;
    check("load1_done_cnt", 32'(done_cnt), 32'd1);
    check("load1_done_latency", 32'(done_cyc - first_cyc + 1), 32'd256);
    check("load1_busy_during", 32'(busy_err), 32'd0);
    check("load1_busy_after", 32'(bus.o_busy), 32'h0);
    @(negedge i_clk);
    #1;
    check("load1_done_single", 32'(bus.o_ld_done), 32'h0);
    @(negedge i_clk);

    // Sweep, then NOP on ce=0, then word 5 again.
    fill_table(1);
    run_table("sweep1");

    // Gapped load with fetch enable high; start and fetch coincide.
    bus.i_ce   = 1'b1;
    bus.i_addr = NPC'(7);
    busy_err   = 0;
    start_load();
    #1;
    check("simul_inst", bus.o_inst, word_of(1, 7));
    check("simul_vld", 32'(bus.o_inst_vld), 32'h1);
    check("simul_busy", 32'(bus.o_busy), 32'h1);
    load_watch = 1'b1;
    for (int k = 0; k < int'(DEPTH); k++) send_word(word_of(2, k), 1'b1);
    #1;
    load_watch = 1'b0;
    check("load2_vld_low", 32'(vld_in_load), 32'd0);
    check("load2_done_cnt", 32'(done_cnt), 32'd2);
    check("load2_busy_during", 32'(busy_err), 32'd0);
    @(negedge i_clk);
    fill_table(2);
    run_table("sweep2");

    // Reset after 10 bytes: words 0,1 kept, partial word 2 dropped.
    bus.i_ce = 1'b0;
    start_load();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] w;
      w = word_of(3, i / 4) >> (24 - 8 * (i % 4));
      send_byte(w[7:0], 1'b0);
    end
    i_rst_n = 1'b0;
    #1;
    check("midrst_flags", 32'({bus.o_inst_vld, bus.o_busy, bus.o_ld_rdy, bus.o_ld_done}), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    fetch_check(NPC'(0), word_of(3, 0), "midrst_w0");
    fetch_check(NPC'(1), word_of(3, 1), "midrst_w1");
    fetch_check(NPC'(2), word_of(2, 2), "midrst_w2_old");
    check("midrst_no_done", 32'(done_cnt), 32'd2);

    // A fresh start writes word 0 first.
    bus.i_ce = 1'b0;
    start_load();
    send_word(32'hDEAD_BEEF, 1'b0);
    #1;
    check("restart_busy", 32'(bus.o_busy), 32'h1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    fetch_check(NPC'(0), 32'hDEAD_BEEF, "restart_w0");
    fetch_check(NPC'(1), word_of(3, 1), "restart_w1");
    check("restart_no_done", 32'(done_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
